// File: rtl/cic_ctrl_pkg.sv
// Shared types and constants for the CIC feed controller.
package cic_ctrl_pkg;

  // Controller state encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_e;

  // Width of the optional underrun event counter.
  localparam int UNDERRUN_CNT_W = 16;

  // Width of the hold-phase counter; never narrower than one bit.
  function automatic int phase_cnt_w(input int interp_rate);
    return (interp_rate <= 2) ? 1 : $clog2(interp_rate);
  endfunction

endpackage

// File: rtl/cic_feed_fifo.sv
// Small synchronous FIFO buffering upstream samples for the CIC feed.
// Clear has priority over push and pop in the same cycle.
module cic_feed_fifo #(
  parameter int BIT_WIDTH  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        clear,
  input  logic [BIT_WIDTH-1:0]        wr_data,
  output logic [BIT_WIDTH-1:0]        rd_data,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        full,
  output logic                        empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_LVL = LW'(FIFO_DEPTH);

  logic [BIT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [LW-1:0]        level_q;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (level_q == DEPTH_LVL);
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Sample storage; contents need no reset since reads only follow a push.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/cic_feed_ctrl.sv
// Sequencer feeding the interpolating CIC of the sigma-delta DAC path.
// Buffers input samples, primes the FIFO, presents each sample as a
// zero-order hold of INTERP_RATE clocks, inserts zeros on underrun and
// flushes the CIC with zeros after stop.
// Optional: define CIC_FEED_UNDERRUN_CNT_EN to build the 16-bit saturating
// underrun counter; otherwise underrun_count is tied to 0.
//
// state | meaning
// IDLE  | stopped, FIFO accepts pushes, CIC disabled
// PRIME | waiting for PRIME_LEVEL samples before enabling the CIC
// RUN   | streaming, one sample (or zero) per hold period
// FLUSH | feeding FLUSH_SAMPLES zeros so the CIC output settles to 0
module cic_feed_ctrl
  import cic_ctrl_pkg::*;
#(
  parameter int BIT_WIDTH     = 4,
  parameter int INTERP_RATE   = 4,
  parameter int FIFO_DEPTH    = 8,
  parameter int PRIME_LEVEL   = 4,
  parameter int FLUSH_SAMPLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        s_valid,
  input  logic [BIT_WIDTH-1:0]        s_data,
  output logic                        s_ready,
  output logic                        cic_enable,
  output logic [BIT_WIDTH-1:0]        cic_data,
  output logic                        cic_strobe,
  output logic                        underrun,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [UNDERRUN_CNT_W-1:0]   underrun_count
);

  localparam int PW = phase_cnt_w(INTERP_RATE);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = $clog2(FLUSH_SAMPLES + 1);
  localparam logic [PW-1:0] PH_LAST    = PW'(INTERP_RATE - 1);
  localparam logic [LW-1:0] PRIME_LVL  = LW'(PRIME_LEVEL);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_SAMPLES);

  state_e               state_q, state_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic [FW-1:0]        flush_cnt_q, flush_cnt_d;
  logic [BIT_WIDTH-1:0] data_q, data_d;
  logic                 strobe_q, strobe_d;
  logic                 under_q, under_d;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_clear;
  logic [BIT_WIDTH-1:0] fifo_head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [LW-1:0]        fifo_lvl;

  cic_feed_fifo #(
    .BIT_WIDTH (BIT_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .clear  (fifo_clear),
    .wr_data(s_data),
    .rd_data(fifo_head),
    .level  (fifo_lvl),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decision; stop wins over start and over priming completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !stop) state_d = PRIME;
      PRIME: begin
        if (stop)                         state_d = IDLE;
        else if (fifo_lvl >= PRIME_LVL)   state_d = RUN;
      end
      RUN:     if (stop) state_d = FLUSH;
      FLUSH:   if (phase_q == PH_LAST && flush_cnt_q == FLUSH_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-state outputs, FIFO control and next values of the hold datapath.
  always_comb begin
    cic_enable  = 1'b0;
    busy        = (state_q != IDLE);
    s_ready     = !rst && !fifo_full && (state_q != FLUSH);
    fifo_pop    = 1'b0;
    fifo_clear  = 1'b0;
    phase_d     = '0;
    flush_cnt_d = flush_cnt_q;
    data_d      = data_q;
    strobe_d    = 1'b0;
    under_d     = 1'b0;
    case (state_q)
      RUN: begin
        cic_enable = 1'b1;
        phase_d    = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
        if (phase_q == '0) begin
          strobe_d = 1'b1;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            data_d   = fifo_head;
          end else begin
            data_d  = '0;
            under_d = 1'b1;
          end
        end
        if (stop) begin
          fifo_clear  = 1'b1;
          flush_cnt_d = '0;
        end
      end
      FLUSH: begin
        cic_enable = 1'b1;
        phase_d    = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
        if (phase_q == '0) begin
          data_d      = '0;
          strobe_d    = 1'b1;
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign fifo_push = s_valid && s_ready;

  // Hold datapath registers: phase, flush progress, presented sample and pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= '0;
      flush_cnt_q <= '0;
      data_q      <= '0;
      strobe_q    <= 1'b0;
      under_q     <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      flush_cnt_q <= flush_cnt_d;
      data_q      <= data_d;
      strobe_q    <= strobe_d;
      under_q     <= under_d;
    end
  end

  assign cic_data   = data_q;
  assign cic_strobe = strobe_q;
  assign underrun   = under_q;
  assign fifo_level = fifo_lvl;

`ifdef CIC_FEED_UNDERRUN_CNT_EN
  logic [UNDERRUN_CNT_W-1:0] ucnt_q, ucnt_d;

  // Saturating count of substituted zeros, restarted whenever priming begins.
  always_comb begin
    ucnt_d = ucnt_q;
    if (state_q == IDLE && state_d == PRIME) ucnt_d = '0;
    else if (under_d && (ucnt_q != '1))      ucnt_d = ucnt_q + 1'b1;
  end

  // Underrun counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ucnt_q <= '0;
    else     ucnt_q <= ucnt_d;
  end

  assign underrun_count = ucnt_q;
`else
  assign underrun_count = '0;
`endif

endmodule
